// File: rtl/decoder_38.sv
// rtl/decoder_38.sv - registered 3-to-8 one-hot decoder with enable; optional hold-on-disable via DECODER38_HOLD_EN
module decoder_38 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] w,
    output logic [7:0] y,
    output logic       valid
);

    // y_q holds the pin-level encoding so the outputs come straight off the flops
    localparam logic [7:0] Y_INACTIVE = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic [7:0] onehot;

    always_comb begin
        onehot = 8'h00;
        for (int i = 0; i < 8; i++) begin
            onehot[i] = (w == 3'(i));
        end
    end

    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        if (en) begin
            y_d     = onehot ^ Y_INACTIVE;
            valid_d = 1'b1;
        end else begin
`ifdef DECODER38_HOLD_EN
            y_d     = y_q;
            valid_d = valid_q;
`else
            y_d     = Y_INACTIVE;
            valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= Y_INACTIVE;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_decoder_38.sv
// tb/tb_decoder_38.sv - self-checking bench for decoder_38 (both polarities, honours DECODER38_HOLD_EN)
module tb_decoder_38;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] w;
    logic [7:0] y_hi;
    logic       valid_hi;
    logic [7:0] y_lo;
    logic       valid_lo;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_y;
    logic       exp_v;

    decoder_38 #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .w(w), .y(y_hi), .valid(valid_hi)
    );

    decoder_38 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .w(w), .y(y_lo), .valid(valid_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert ($countones(y_hi) <= 1) else $error("multi-hot y_hi=%h", y_hi);
        assert ($countones(~y_lo) <= 1) else $error("multi-hot y_lo=%h", y_lo);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y"}, y_hi, exp_y);
        check({tag, ".valid"}, {7'd0, valid_hi}, {7'd0, exp_v});
        check({tag, ".y_al"}, y_lo, ~exp_y);
        check({tag, ".valid_al"}, {7'd0, valid_lo}, {7'd0, exp_v});
    endtask

    // Reference: an enabled decode yields 2**w as an 8-bit word
    task automatic model_edge(input logic e, input logic [2:0] ww);
        int p;
        if (e) begin
            p = 1;
            for (int k = 0; k < int'(ww); k++) p = p * 2;
            exp_y = p[7:0];
            exp_v = 1'b1;
        end else begin
`ifndef DECODER38_HOLD_EN
            exp_y = 8'h00;
            exp_v = 1'b0;
`endif
        end
    endtask

    task automatic step(input string tag, input logic e, input logic [2:0] ww);
        @(negedge clk);
        en = e;
        w  = ww;
        @(posedge clk);
        model_edge(e, ww);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        w     = 3'd4;
        exp_y = 8'h00;
        exp_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        step("first_after_release", 1'b1, 3'd1);

        for (int i = 0; i < 8; i++) step("sweep", 1'b1, 3'(i));

        step("en_low_pre", 1'b1, 3'd3);
        step("en_low_1", 1'b0, 3'd6);
        step("en_low_2", 1'b0, 3'd6);
        step("en_recover", 1'b1, 3'd2);

        for (int i = 0; i < 10; i++) step("alt_0_7", 1'b1, (i % 2 == 0) ? 3'd0 : 3'd7);

        // Asynchronous reset in the middle of a cycle with a live decode request
        @(negedge clk);
        en = 1'b1;
        w  = 3'd5;
        #2;
        rst_n = 1'b0;
        exp_y = 8'h00;
        exp_v = 1'b0;
        #1;
        check_all("async_reset_now");
        @(posedge clk);
        #1;
        check_all("async_reset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("release_before_edge");
        @(posedge clk);
        model_edge(1'b1, 3'd5);
        #1;
        check_all("release_first_edge");
        check("release_literal", y_hi, 8'h20);

        for (int i = 0; i < 200; i++) begin
            step("random", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
